// File: rtl/fp_divider_pkg.sv
// Shared constants, FSM encodings and operand classes for the single-precision divider.
package fp_divider_pkg;
  localparam int EXP_W  = 8;
  localparam int MANT_W = 23;
  localparam int BIAS   = 127;
  localparam int QBITS  = MANT_W + 4;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, ROUND, FINISH} state_e;
  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} op_class_e;

  // Denormals fold into ZERO; results never denormalize.
  function automatic op_class_e classify(input logic [31:0] x);
    if (x[MANT_W+EXP_W-1:MANT_W] == '0) return ZERO;
    if (x[MANT_W+EXP_W-1:MANT_W] != '1) return NORM;
    if (x[MANT_W-1:0] == '0) return INF;
    return NAN;
  endfunction
endpackage

// File: rtl/fp_div_special.sv
// Combinational classifier: flags operand pairs whose quotient needs no mantissa division.
module fp_div_special
  import fp_divider_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        special_o,
  output logic [31:0] result_o,
  output logic        exc_o
);
  op_class_e cls_a, cls_b;
  logic      sign;

  always_comb begin
    cls_a     = classify(a_i);
    cls_b     = classify(b_i);
    sign      = a_i[31] ^ b_i[31];
    special_o = 1'b1;
    result_o  = QNAN;
    exc_o     = 1'b1;
    if (cls_a == NAN || cls_b == NAN || (cls_a == ZERO && cls_b == ZERO) ||
        (cls_a == INF && cls_b == INF)) begin
      result_o = QNAN;
    end else if (cls_a == INF) begin
      result_o = {sign, 8'hFF, 23'h0};
      exc_o    = 1'b0;
    end else if (cls_b == ZERO) begin
      result_o = {sign, 8'hFF, 23'h0};
    end else if (cls_a == ZERO || cls_b == INF) begin
      result_o = {sign, 31'h0};
      exc_o    = 1'b0;
    end else begin
      special_o = 1'b0;
      result_o  = '0;
      exc_o     = 1'b0;
    end
  end
endmodule

// File: rtl/fp_divider.sv
// Iterative IEEE-754 single divider (radix-2 restoring), out = A / B.
// Define FP_DIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
//   state  | meaning
//   IDLE   | waiting for start
//   CHECK  | special-operand screen, sign/exponent setup
//   DIVIDE | ITERS_PER_CYCLE quotient bits per clock, 27 in total
//   ROUND  | normalize, round, overflow/underflow
//   FINISH | publish out/exception, pulse done
module fp_divider
  import fp_divider_pkg::*;
#(
  parameter int ITERS_PER_CYCLE = 1
) (
  input  logic        control,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] out,
  output logic        exception
);
  localparam int DIV_CYCLES = QBITS / ITERS_PER_CYCLE;
  localparam logic [4:0] CNT_LOAD = 5'(DIV_CYCLES - 1);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d;
  logic [24:0]        rem_q, rem_d;
  logic [QBITS-1:0]   quo_q, quo_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [31:0]        res_q, res_d, out_q, out_d;
  logic               res_exc_q, res_exc_d, exc_q, exc_d;
  logic               busy_q, busy_d, done_q, done_d;

  logic               spec_flag, spec_exc;
  logic [31:0]        spec_res;

  fp_div_special u_special (
    .a_i       (a_q),
    .b_i       (b_q),
    .special_o (spec_flag),
    .result_o  (spec_res),
    .exc_o     (spec_exc)
  );

  logic [24:0]      rem_step;
  logic [QBITS-1:0] quo_step;
  logic [23:0]      div_mant;

  always_comb begin
    div_mant = {1'b1, b_q[MANT_W-1:0]};
    rem_step = rem_q;
    quo_step = quo_q;
    for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
      if (rem_step >= {1'b0, div_mant}) begin
        rem_step = rem_step - {1'b0, div_mant};
        quo_step = {quo_step[QBITS-2:0], 1'b1};
      end else begin
        quo_step = {quo_step[QBITS-2:0], 1'b0};
      end
      rem_step = rem_step << 1;
    end
  end

  logic [22:0]       mant_t;
  logic [23:0]       mant_sum;
  logic signed [9:0] exp_r;
  logic              round_up;
  logic [31:0]       round_res;
  logic              round_exc;
`ifdef FP_DIV_RNE_EN
  logic              guard_b, round_b, sticky_b;
`endif

  always_comb begin
    if (quo_q[QBITS-1]) begin
      mant_t = quo_q[25:3];
      exp_r  = exp_q;
    end else begin
      mant_t = quo_q[24:2];
      exp_r  = exp_q - 10'sd1;
    end
`ifdef FP_DIV_RNE_EN
    guard_b  = quo_q[QBITS-1] ? quo_q[2] : quo_q[1];
    round_b  = quo_q[QBITS-1] ? quo_q[1] : quo_q[0];
    sticky_b = (|rem_q) | (quo_q[QBITS-1] & quo_q[0]);
    round_up = guard_b & (round_b | sticky_b | mant_t[0]);
`else
    round_up = 1'b0;
`endif
    mant_sum = {1'b0, mant_t} + 24'(round_up);
    if (mant_sum[23]) exp_r = exp_r + 10'sd1;
    round_exc = 1'b1;
    if (exp_r >= 10'sd255) begin
      round_res = {sign_q, 8'hFF, 23'h0};
    end else if (exp_r <= 10'sd0) begin
      round_res = {sign_q, 31'h0};
    end else begin
      round_res = {sign_q, exp_r[7:0], mant_sum[22:0]};
      round_exc = 1'b0;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    sign_d    = sign_q;
    exp_d     = exp_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    cnt_d     = cnt_q;
    res_d     = res_q;
    res_exc_d = res_exc_q;
    out_d     = out_q;
    exc_d     = exc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          busy_d  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (spec_flag) begin
          res_d     = spec_res;
          res_exc_d = spec_exc;
          state_d   = FINISH;
        end else begin
          sign_d  = a_q[31] ^ b_q[31];
          exp_d   = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]})
                    + $signed(10'(BIAS));
          rem_d   = {2'b01, a_q[MANT_W-1:0]};
          quo_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = rem_step;
        quo_d = quo_step;
        if (cnt_q == 5'd0) state_d = ROUND;
        else cnt_d = cnt_q - 5'd1;
      end
      ROUND: begin
        res_d     = round_res;
        res_exc_d = round_exc;
        state_d   = FINISH;
      end
      FINISH: begin
        out_d   = res_q;
        exc_d   = res_exc_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge control or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      cnt_q     <= '0;
      res_q     <= '0;
      res_exc_q <= 1'b0;
      out_q     <= '0;
      exc_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sign_q    <= sign_d;
      exp_q     <= exp_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      res_exc_q <= res_exc_d;
      out_q     <= out_d;
      exc_q     <= exc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out       = out_q;
  assign exception = exc_q;
endmodule
